// File: rtl/mem_if_ctrl.sv
// Load/store request FSM between the instruction unit and system memory.
// Optional response watchdog: define MEM_IF_TIMEOUT_EN.
module mem_if_ctrl #(
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 16,
    parameter int OPERAND_W      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 store,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    result,
    input  logic                 mem_resp,
    input  logic [DATA_W-1:0]    datafrommem,
    output logic [DATA_W-1:0]    datatomem,
    output logic [OPERAND_W-1:0] datatoinst,
    output logic                 read_req,
    output logic                 write_req,
    output logic                 cs,
    output logic [ADDR_W-1:0]    addrout,
    output logic                 mem_done,
    output logic                 mem_busy,
    output logic                 mem_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                r_state, w_next_state;
    logic                  r_armed, w_armed;
    logic                  r_is_load, w_is_load;
    logic [DATA_W-1:0]     r_datatomem, w_datatomem;
    logic [OPERAND_W-1:0]  r_datatoinst, w_datatoinst;
    logic                  r_read_req, w_read_req;
    logic                  r_write_req, w_write_req;
    logic [ADDR_W-1:0]     r_addrout, w_addrout;
    logic                  r_mem_done, w_mem_done;
    logic                  r_mem_busy;
    logic                  w_accept;
    logic                  w_timeout;
    logic                  w_finish;

    // A command is taken only after both lines have been seen low (edge qualification).
    assign w_accept = (r_state == IDLE) && r_armed && (load || store);
    assign w_finish = (r_state == REQ) && (mem_resp || w_timeout);

`ifdef MEM_IF_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wdog;
    logic            r_mem_err;

    assign w_timeout = (r_state == REQ) && !mem_resp && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= w_timeout;
            if (w_accept)
                r_wdog <= '0;
            else if (r_state == REQ && !mem_resp)
                r_wdog <= r_wdog + 1'b1;
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // State and registered-output process.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_armed      <= 1'b0;
            r_is_load    <= 1'b0;
            r_datatomem  <= '0;
            r_datatoinst <= '0;
            r_read_req   <= 1'b0;
            r_write_req  <= 1'b0;
            r_addrout    <= '0;
            r_mem_done   <= 1'b0;
            r_mem_busy   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state      <= w_next_state;
            r_armed      <= w_armed;
            r_is_load    <= w_is_load;
            r_datatomem  <= w_datatomem;
            r_datatoinst <= w_datatoinst;
            r_read_req   <= w_read_req;
            r_write_req  <= w_write_req;
            r_addrout    <= w_addrout;
            r_mem_done   <= w_mem_done;
            r_mem_busy   <= (w_next_state != IDLE);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = REQ;
            REQ:     if (w_finish) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        w_armed      = r_armed;
        w_is_load    = r_is_load;
        w_datatomem  = r_datatomem;
        w_datatoinst = r_datatoinst;
        w_read_req   = r_read_req;
        w_write_req  = r_write_req;
        w_addrout    = r_addrout;
        w_mem_done   = 1'b0;

        if (!load && !store)
            w_armed = 1'b1;
        else if (w_accept)
            w_armed = 1'b0;

        if (w_accept) begin
            w_addrout = addr;
            w_is_load = load;
            if (load) begin
                w_read_req = 1'b1;
            end else begin
                w_write_req = 1'b1;
                w_datatomem = result;
            end
        end

        if (w_finish) begin
            w_read_req  = 1'b0;
            w_write_req = 1'b0;
            w_mem_done  = 1'b1;
            if (mem_resp && r_is_load)
                w_datatoinst = r_addrout[0] ? datafrommem[DATA_W-1:OPERAND_W]
                                            : datafrommem[OPERAND_W-1:0];
        end
    end

    assign datatomem  = r_datatomem;
    assign datatoinst = r_datatoinst;
    assign read_req   = r_read_req;
    assign write_req  = r_write_req;
    assign cs         = r_read_req | r_write_req;
    assign addrout    = r_addrout;
    assign mem_done   = r_mem_done;
    assign mem_busy   = r_mem_busy;

endmodule

// File: tb/tb_mem_if_ctrl.sv
// Directed-vector bench for mem_if_ctrl; timeout vectors build only with MEM_IF_TIMEOUT_EN.
module tb_mem_if_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load, store, mem_resp;
    logic [13:0] addr;
    logic [15:0] result, datafrommem;
    logic [15:0] datatomem;
    logic [7:0]  datatoinst;
    logic        read_req, write_req, cs, mem_done, mem_busy, mem_err;
    logic [13:0] addrout;

    int n_vec = 0;
    int n_bad = 0;

    mem_if_ctrl #(
        .ADDR_W(14), .DATA_W(16), .OPERAND_W(8), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .store(store),
        .addr(addr), .result(result), .mem_resp(mem_resp),
        .datafrommem(datafrommem), .datatomem(datatomem),
        .datatoinst(datatoinst), .read_req(read_req), .write_req(write_req),
        .cs(cs), .addrout(addrout), .mem_done(mem_done),
        .mem_busy(mem_busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, respond on the wait_cyc-th edge after acceptance, and tally outputs.
    task automatic access(input logic ld, input logic st, input logic [13:0] a,
                          input logic [15:0] wd, input int wait_cyc, input logic [15:0] rd,
                          output int rr, output int wr, output int dn, output int er,
                          output logic [13:0] a_req, output logic [15:0] d_req);
        rr = 0; wr = 0; dn = 0; er = 0;
        load = ld; store = st; addr = a; result = wd;
        tick();
        load = 1'b0; store = 1'b0; addr = ~a; result = 16'hFFFF;
        rr += int'(read_req); wr += int'(write_req); dn += int'(mem_done); er += int'(mem_err);
        for (int i = 1; i < wait_cyc; i++) begin
            tick();
            rr += int'(read_req); wr += int'(write_req); dn += int'(mem_done); er += int'(mem_err);
        end
        a_req = addrout; d_req = datatomem;
        mem_resp = 1'b1; datafrommem = rd;
        tick();
        mem_resp = 1'b0; datafrommem = 16'h0000;
        rr += int'(read_req); wr += int'(write_req); dn += int'(mem_done); er += int'(mem_err);
        tick();
        rr += int'(read_req); wr += int'(write_req); dn += int'(mem_done); er += int'(mem_err);
    endtask

    int rr, wr, dn, er, both;
    logic [13:0] a_req;
    logic [15:0] d_req;

    initial begin
        reset_n = 1'b0; load = 0; store = 0; mem_resp = 0;
        addr = 0; result = 0; datafrommem = 0;
        #2;
        check("rst_ctrl", {read_req, write_req, cs, mem_done, mem_busy, mem_err}, 0);
        check("rst_data", {addrout, datatomem, datatoinst}, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Load, odd address -> upper byte, response on third edge.
        access(1, 0, 14'h0003, 16'h0, 3, 16'hA55A, rr, wr, dn, er, a_req, d_req);
        check("ld_rr_cycles", rr, 3);
        check("ld_wr_cycles", wr, 0);
        check("ld_done",      dn, 1);
        check("ld_err",       er, 0);
        check("ld_addrout",   a_req, 14'h0003);
        check("ld_operand",   datatoinst, 8'hA5);
        check("ld_idle",      {mem_busy, cs, mem_done}, 0);

        // Store; result changes during REQ and must not leak through.
        access(0, 1, 14'h3FFF, 16'h1234, 2, 16'hDEAD, rr, wr, dn, er, a_req, d_req);
        check("st_wr_cycles", wr, 2);
        check("st_rr_cycles", rr, 0);
        check("st_done",      dn, 1);
        check("st_datareq",   d_req, 16'h1234);
        check("st_datatomem", datatomem, 16'h1234);
        check("st_addrout",   addrout, 14'h3FFF);
        check("st_operand",   datatoinst, 8'hA5);

        // Held load with permanent response -> exactly one access.
        rr = 0; dn = 0;
        addr = 14'h0010; datafrommem = 16'h3C5A; mem_resp = 1'b1; load = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            rr += int'(read_req); dn += int'(mem_done);
        end
        check("hold_rr",      rr, 1);
        check("hold_done",    dn, 1);
        check("hold_operand", datatoinst, 8'h5A);
        load = 1'b0; tick();
        load = 1'b1; datafrommem = 16'h96C3; dn = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            dn += int'(mem_done);
        end
        check("rearm_done",    dn, 1);
        check("rearm_operand", datatoinst, 8'hC3);
        load = 1'b0; mem_resp = 1'b0; datafrommem = 0;
        tick();

        // Simultaneous load and store -> load wins.
        access(1, 1, 14'h0002, 16'h5555, 1, 16'hBEEF, rr, wr, dn, er, a_req, d_req);
        check("both_rr",      rr, 1);
        check("both_wr",      wr, 0);
        check("both_operand", datatoinst, 8'hEF);
        check("both_dtm",     datatomem, 16'h1234);

`ifdef MEM_IF_TIMEOUT_EN
        // No response: four request cycles, then done+err together.
        rr = 0; dn = 0; er = 0; both = 0;
        addr = 14'h0021; load = 1'b1;
        tick();
        load = 1'b0;
        rr += int'(read_req);
        for (int i = 0; i < 8; i++) begin
            tick();
            rr += int'(read_req); dn += int'(mem_done); er += int'(mem_err);
            both += int'(mem_done && mem_err);
        end
        check("to_rr",      rr, 4);
        check("to_done",    dn, 1);
        check("to_err",     er, 1);
        check("to_coinc",   both, 1);
        check("to_operand", datatoinst, 8'hEF);
        access(1, 0, 14'h0001, 16'h0, 4, 16'h6611, rr, wr, dn, er, a_req, d_req);
        check("to_late_rr",  rr, 4);
        check("to_late_err", er, 0);
        check("to_late_op",  datatoinst, 8'h66);
`endif

        // Reset during REQ clears everything asynchronously, no done.
        addr = 14'h0005; load = 1'b1;
        tick();
        load = 1'b0;
        check("ab_req", read_req, 1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("ab_ctrl", {read_req, write_req, cs, mem_done, mem_busy, mem_err}, 0);
        check("ab_data", {addrout, datatomem, datatoinst}, 0);
        dn = 0;
        mem_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            dn += int'(mem_done);
        end
        mem_resp = 1'b0;
        reset_n = 1'b1;
        tick();
        dn += int'(mem_done);
        check("ab_nodone", dn, 0);
        access(1, 0, 14'h0001, 16'h0, 2, 16'h7788, rr, wr, dn, er, a_req, d_req);
        check("post_done",    dn, 1);
        check("post_operand", datatoinst, 8'h77);
        check("post_addr",    addrout, 14'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_if_ctrl.md
# mem_if_ctrl

Parametrised memory interface controller between the instruction unit and the system memory (MSS). It replaces the free-running counter handshake with an explicit request/response FSM and adds generic address/data widths, byte-lane selection on loads, edge-qualified command acceptance, and an optional response watchdog. One load or store is in flight at a time. Completion is reported to the instruction unit with a single-cycle `mem_done` pulse.

## Interface
- `ADDR_W`, 14: address width; covers 16 KB system memory.
- `DATA_W`, 16: memory data width.
- `OPERAND_W`, 8: load operand width. `DATA_W` must equal 2*`OPERAND_W`.
- `TIMEOUT_CYCLES`, 16: watchdog limit in cycles. Used only with `MEM_IF_TIMEOUT_EN`. Must be ≥1.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `load` in 1: level; load command from the instruction unit.
- `store` in 1: level; store command from the instruction unit.
- `addr` in ADDR_W: byte address from the instruction unit.
- `result` in DATA_W: store data from the instruction unit.
- `mem_resp` in 1: response from the MSS.
- `datafrommem` in DATA_W: read data from the MSS, valid with `mem_resp`.
- `datatomem` out DATA_W: write data to the MSS.
- `datatoinst` out OPERAND_W: load operand to the instruction unit.
- `read_req` out 1: read request to the MSS.
- `write_req` out 1: write request to the MSS.
- `cs` out 1: chip select; equals `read_req | write_req`, combinational.
- `addrout` out ADDR_W: registered address to the MSS.
- `mem_done` out 1: one-cycle completion pulse.
- `mem_busy` out 1: high while state ≠ IDLE.
- `mem_err` out 1: one-cycle pulse coincident with `mem_done` on a timeout. Constant 0 when `MEM_IF_TIMEOUT_EN` is undefined.

## Operation
- Reset value 0 for all registered outputs and internal state: `datatomem`, `datatoinst`, `read_req`, `write_req`, `addrout`, `mem_done`, `mem_busy`, `mem_err`, the `armed` flag, and the watchdog counter. State resets to IDLE.
- FSM states: IDLE, REQ, DONE.
- `armed` flag:
  - Set on any cycle where `load` = `store` = 0.
  - Cleared when a command is accepted.
  - A held command level never issues a second access.
  - After reset, each command line must be low for at least one cycle before it can be accepted.
- IDLE → REQ: taken when `armed` & (`load` | `store`).
  - Latch `addr` into `addrout`.
  - Latch op type. `load` has priority if both are high.
  - Store: latch `result` into `datatomem`.
  - Set `read_req` (load) or `write_req` (store).
  - Clear the watchdog.
- REQ: hold the request, `addrout` and `datatomem` stable. Input changes are ignored.
- REQ with `mem_resp` = 1:
  - Clear the request.
  - Load: `datatoinst` <= `addrout[0]` ? `datafrommem[DATA_W-1:OPERAND_W]` : `datafrommem[OPERAND_W-1:0]`.
  - Pulse `mem_done`.
  - Next state DONE.
- DONE: `mem_done` returns to 0 and the state returns to IDLE. No command is accepted in DONE.
- `datatoinst` holds its value until the next completed load. Stores and timeouts leave it unchanged.
- `mem_resp` outside REQ is ignored.
- Reset asserted mid-operation clears the request and all state immediately. No `mem_done` is issued for the aborted access.

## Timing
- Accept edge is t0. `read_req`/`write_req` are high from t0 onward.
- Earliest `mem_resp` is sampled at edge t1. `mem_done` and `datatoinst` are then valid in cycle t1–t2.
- Minimum latency from the accept edge to `mem_done`: 1 cycle.
- Minimum issue interval: 3 cycles, because DONE blocks acceptance and `armed` requires the command to go low between accesses.
- `mem_busy` is high from t0 until the DONE→IDLE edge.
- `cs` follows the requests with no added delay.

## Configuration
- `MEM_IF_TIMEOUT_EN` defined:
  - The counter increments on each REQ cycle without `mem_resp`.
  - At the edge ending the `TIMEOUT_CYCLES`-th request-high cycle with no response: clear the request, pulse `mem_done` and `mem_err` together, go to DONE.
  - If `mem_resp` arrives on that same edge, normal completion wins and `mem_err` stays 0.
- `MEM_IF_TIMEOUT_EN` undefined: no counter; REQ waits indefinitely; `mem_err` is tied to 0.

## Test plan
- Reset, then `load` with `addr`=0x0003, `mem_resp` 2 cycles later, `datafrommem`=0xA55A -> `read_req` high 3 cycles, `addrout`=0x0003, `datatoinst`=0xA5, one `mem_done` pulse, `mem_err`=0.
- `store` with `result`=0x1234, `addr`=0x3FFF; `result` changed to 0xFFFF during REQ; response after 1 cycle -> `datatomem`=0x1234, `addrout`=0x3FFF held, `write_req` high 2 cycles, `datatoinst` unchanged.
- `load` held high for 20 cycles, `mem_resp` always high -> exactly one access and one `mem_done`. Drop `load` for 1 cycle and reassert -> second access.
- `load` and `store` asserted in the same cycle -> read issued, `write_req` stays 0.
- With `MEM_IF_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no `mem_resp` -> `read_req` high 4 cycles, then `mem_done` = `mem_err` = 1 for one cycle. With `mem_resp` on the 4th cycle -> `mem_err`=0.
- `reset_n` pulsed low during REQ -> all outputs 0 asynchronously, no `mem_done`. Afterwards a new load completes normally.
